// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci UART client.
// Holds the FSM encoding and the default result width.
package fib_pkg;

  localparam int DEF_NB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/fib_core.sv
// Iterative Fibonacci engine: a/b/cnt stepping plus wrap detect.
// done is high on the single cycle the result in a is final.
module fib_core
  import fib_pkg::*;
#(
  parameter int W = 8 * DEF_NB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   n,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [7:0]   cnt;
  logic         run;
  logic [W:0]   sum;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign done   = run && (cnt == 8'd0);
  assign result = a;

  // Load on start, then step once per cycle until cnt runs out.
  // A carry on the last step lands only in b, so it is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      cnt <= '0;
      run <= 1'b0;
      ovf <= 1'b0;
    end else if (start) begin
      a   <= '0;
      b   <= W'(1);
      cnt <= n;
      run <= 1'b1;
      ovf <= 1'b0;
    end else if (run) begin
      if (cnt != 8'd0) begin
        a   <= b;
        b   <= sum[W-1:0];
        cnt <= cnt - 8'd1;
        if (sum[W] && (cnt >= 8'd2)) begin
          ovf <= 1'b1;
        end
      end else begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fib_uart_ctrl.sv
// UART FIFO client: pops N, computes F(N), pushes NB bytes MSB first.
// Owns the FSM, the rx/tx strobes and the byte serializer.
module fib_uart_ctrl
  import fib_pkg::*;
#(
  parameter int NB = DEF_NB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       ovf
);

  localparam int W = 8 * NB;
  localparam logic [2:0] LAST = 3'(NB - 1);

  state_t       state;
  logic [W-1:0] sh;
  logic [2:0]   idx;
  logic         core_done;
  logic [W-1:0] core_result;

  // Strobes are combinational so a pop/push costs no extra cycle.
  assign rd_uart = (state == IDLE) && !rx_empty && !reset;
  assign wr_uart = (state == SEND) && !tx_full && !reset;
  assign w_data  = sh[W-1:W-8];
  assign busy    = (state != IDLE);

  fib_core #(
    .W (W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (rd_uart),
    .n      (r_data),
    .done   (core_done),
    .result (core_result),
    .ovf    (ovf)
  );

  // Command sequencing and MSB-first byte serializer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_uart) begin
            state <= CALC;
          end
        end
        CALC: begin
          if (core_done) begin
            sh    <= core_result;
            idx   <= LAST;
            state <= SEND;
          end
        end
        SEND: begin
          if (wr_uart) begin
            sh  <= sh << 8;
            idx <= idx - 3'd1;
            if (idx == 3'd0) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_uart_ctrl.sv
// Bench for fib_uart_ctrl: FIFO models, F(N) reference model,
// per-cycle strobe/data checks and literal test-plan expectations.
module tb_fib_uart_ctrl;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;
  logic       ovf;

  fib_uart_ctrl #(.NB(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] log_q[$];
  int         pop_cyc[$];
  int         push_cyc[$];

  int  cyc_no = 0;
  int  out_bytes = 0;
  int  since = 0;
  int  cur_n = 0;
  int  first_push = -1;
  int  pushes = 0;
  bit  exp_ovf = 1'b0;
  bit  had_cmd = 1'b0;
  bit  stall_arm = 1'b0;
  int  stall_left = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // True-value Fibonacci alongside the wrapped one; overflow means
  // the true F(N) does not fit in 32 bits.
  function automatic void fib_model(input int n,
                                    output logic [31:0] r,
                                    output bit o);
    longint unsigned ta = 0, tb = 1, tt;
    logic [31:0] wa = 0, wb = 1, wt;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      wt = wa + wb;
      wa = wb;
      wb = wt;
      if (!o) begin
        tt = ta + tb;
        ta = tb;
        tb = tt;
        if (ta >= 64'h1_0000_0000) o = 1'b1;
      end
    end
    r = wa;
  endfunction

  task automatic drive_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic send(input logic [7:0] n);
    rxq.push_back(n);
    drive_rx();
  endtask

  task automatic model_clear();
    out_bytes = 0;
    expq.delete();
    exp_ovf = 1'b0;
    had_cmd = 1'b0;
    stall_left = 0;
    tx_full = 1'b0;
  endtask

  // One cycle: sample at negedge, check against the model, advance
  // the model, then update the FIFO-side inputs after the edge.
  task automatic tick();
    bit rd_s, wr_s, exp_rd, exp_wr;
    logic [7:0] wd, rdat, eb, pv;
    logic [31:0] r;
    bit o;
    @(negedge clk);
    rd_s = rd_uart;
    wr_s = wr_uart;
    wd   = w_data;
    rdat = r_data;
    exp_rd = !reset && out_bytes == 0 && rxq.size() > 0;
    exp_wr = out_bytes > 0 && since >= cur_n + 2 && !tx_full;
    chk("rd_uart", rd_s, exp_rd);
    chk("wr_uart", wr_s, exp_wr);
    chk("busy", busy, out_bytes > 0);
    if (reset) begin
      chk("w_data_rst", wd, 8'h00);
      chk("ovf_rst", ovf, 1'b0);
    end else if ((out_bytes > 0 && since >= cur_n + 2) ||
                 (out_bytes == 0 && had_cmd)) begin
      chk("ovf", ovf, exp_ovf);
    end
    if (wr_s) begin
      if (expq.size() == 0) begin
        chk("push_unexpected", 1, 0);
      end else begin
        eb = expq.pop_front();
        chk("w_data", wd, eb);
      end
      log_q.push_back(wd);
      push_cyc.push_back(cyc_no);
      if (first_push < 0) first_push = since;
      pushes++;
      if (out_bytes > 0) out_bytes--;
      if (stall_arm && pushes == 2) begin
        stall_arm = 1'b0;
        stall_left = 5;
      end
    end
    since++;
    if (rd_s) begin
      cur_n = int'(rdat);
      fib_model(cur_n, r, o);
      exp_ovf = o;
      for (int k = NB - 1; k >= 0; k--) expq.push_back(r[k*8 +: 8]);
      out_bytes = NB;
      since = 1;
      pushes = 0;
      first_push = -1;
      had_cmd = 1'b1;
      pop_cyc.push_back(cyc_no);
    end
    cyc_no++;
    @(posedge clk);
    #1;
    if (rd_s && rxq.size() > 0) pv = rxq.pop_front();
    drive_rx();
    if (stall_left > 0) begin
      tx_full = 1'b1;
      stall_left--;
    end else begin
      tx_full = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((out_bytes > 0 || rxq.size() > 0) && n < budget);
    if (n >= budget) chk("idle_timeout", n, budget - 1);
    tick();
    tick();
  endtask

  task automatic start_test();
    log_q.delete();
    pop_cyc.delete();
    push_cyc.delete();
  endtask

  task automatic check_log(input string nm, input logic [63:0] exp,
                           input int nbytes);
    chk({nm, "_count"}, log_q.size(), nbytes);
    for (int i = 0; i < nbytes && i < log_q.size(); i++)
      chk({nm, "_byte"}, log_q[i], exp[(nbytes-1-i)*8 +: 8]);
  endtask

  initial begin
    reset = 1'b1;
    tx_full = 1'b0;
    drive_rx();
    model_clear();
    tick();
    tick();
    reset = 1'b0;

    // N=0
    start_test();
    send(8'h00);
    wait_idle(100);
    check_log("n0", 64'h0000_0000, 4);
    chk("n0_ovf", ovf, 1'b0);

    // N=10, latency
    start_test();
    send(8'd10);
    wait_idle(100);
    check_log("n10", 64'h0000_0037, 4);
    chk("n10_latency", first_push, 12);
    chk("n10_ovf", ovf, 1'b0);

    // N=47, last-step carry only
    start_test();
    send(8'd47);
    wait_idle(200);
    check_log("n47", 64'hB119_24E1, 4);
    chk("n47_ovf", ovf, 1'b0);

    // N=48 wraps, then N=1 clears ovf
    start_test();
    send(8'd48);
    wait_idle(200);
    check_log("n48", 64'h1E8D_0A40, 4);
    chk("n48_ovf", ovf, 1'b1);
    start_test();
    send(8'd1);
    wait_idle(100);
    check_log("n1", 64'h0000_0001, 4);
    chk("n1_ovf", ovf, 1'b0);

    // N=10 with tx stall after the 2nd push
    start_test();
    stall_arm = 1'b1;
    send(8'd10);
    wait_idle(100);
    check_log("stall", 64'h0000_0037, 4);
    chk("stall_gap", push_cyc[2] - push_cyc[1], 6);

    // Two queued commands
    start_test();
    rxq.push_back(8'd5);
    send(8'd6);
    wait_idle(200);
    check_log("pair", 64'h0000_0005_0000_0008, 8);
    chk("pair_npop", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2 && push_cyc.size() >= 4)
      chk("pair_pop2", pop_cyc[1], push_cyc[3] + 1);

    // Reset mid-CALC for N=200
    start_test();
    send(8'd200);
    for (int i = 0; i < 40; i++) tick();
    #1;
    reset = 1'b1;
    #1;
    chk("rst_rd", rd_uart, 1'b0);
    chk("rst_wr", wr_uart, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wdata", w_data, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    model_clear();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_nopush", log_q.size(), 0);
    start_test();
    send(8'd2);
    wait_idle(100);
    check_log("n2", 64'h0000_0001, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
